// File: rtl/alu_issue_sched_pkg.sv
// Shared types for the ALU issue scheduler: functional-unit tag type and scheduler states.
package alu_issue_sched_pkg;

  localparam int FU_ADDR_W = 4;

  typedef logic [FU_ADDR_W-1:0] fu_addr_t;

  localparam fu_addr_t FU_NULL = '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RES  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/alu_issue_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request at or after i_ptr (wrapping).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_idx
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = PW'(w_idx);
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue scheduler for one latched ALU: round-robin slot grant, result hold until CDB accept.
//   state  | meaning
//   S_IDLE | ALU holds no unconsumed result
//   S_RES  | ALU result valid, waiting for CDB grant (alu_done expected 1)
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ-1:0][XLEN-1:0]  i_req_a,
  input  logic [NREQ-1:0][XLEN-1:0]  i_req_b,
  input  logic [NREQ-1:0][2:0]       i_req_funct3,
  input  logic [NREQ-1:0]            i_req_opt,
  input  fu_addr_t [NREQ-1:0]        i_req_tag,
  output logic [NREQ-1:0]            o_gnt,
  output logic [XLEN-1:0]            o_alu_in_a,
  output logic [XLEN-1:0]            o_alu_in_b,
  output logic [2:0]                 o_alu_funct3,
  output logic                       o_alu_opt,
  output fu_addr_t                   o_alu_addr_in,
  output logic                       o_alu_init,
  output logic                       o_alu_ack,
  input  logic                       i_alu_done,
  input  logic [XLEN-1:0]            i_alu_fu_out,
  input  fu_addr_t                   i_alu_addr_out,
  output logic                       o_cdb_req,
  output logic [XLEN-1:0]            o_cdb_data,
  output fu_addr_t                   o_cdb_tag,
  input  logic                       i_cdb_gnt,
  output logic [31:0]                o_issue_cnt,
  output logic                       o_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t    r_state;
  sched_state_t    w_state_nxt;
  logic [PW-1:0]   r_rr_ptr;
  logic [31:0]     r_issue_cnt;
  logic            r_err;

  logic            w_in_res;
  logic            w_cdb_fire;
  logic            w_can_issue;
  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;

  assign w_in_res    = (r_state == S_RES);
  assign o_cdb_req   = rst_n & w_in_res & ~i_flush;
  assign w_cdb_fire  = o_cdb_req & i_cdb_gnt;
  assign w_can_issue = rst_n & ~i_flush & (~w_in_res | w_cdb_fire);
  assign w_arb_req   = i_req & {NREQ{w_can_issue}};

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .i_req     (w_arb_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_gnt      = w_gnt;
  assign o_alu_init = |w_gnt;
  // A flush in S_RES still acks so the ALU discards the pending result.
  assign o_alu_ack  = rst_n & (w_cdb_fire | (i_flush & w_in_res));

  always_comb begin
    o_alu_in_a    = '0;
    o_alu_in_b    = '0;
    o_alu_funct3  = '0;
    o_alu_opt     = 1'b0;
    o_alu_addr_in = FU_NULL;
    if (o_alu_init) begin
      o_alu_in_a    = i_req_a[w_gnt_idx];
      o_alu_in_b    = i_req_b[w_gnt_idx];
      o_alu_funct3  = i_req_funct3[w_gnt_idx];
      o_alu_opt     = i_req_opt[w_gnt_idx];
      o_alu_addr_in = i_req_tag[w_gnt_idx];
    end
  end

  assign o_cdb_data  = i_alu_fu_out;
  assign o_cdb_tag   = i_alu_addr_out;
  assign o_issue_cnt = r_issue_cnt;
  assign o_err       = r_err;

  // Stay in S_RES while the result waits on the CDB; a new issue always lands in S_RES.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (o_alu_init || (w_in_res && !i_flush && !i_cdb_gnt)) begin
      w_state_nxt = S_RES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_issue_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (o_alu_init) begin
        r_rr_ptr    <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (i_alu_done != w_in_res) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched with a behavioural latched-ALU model on the result side.
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int XLEN = 32;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic [NREQ-1:0][2:0]      req_funct3;
  logic [NREQ-1:0]           req_opt;
  fu_addr_t [NREQ-1:0]       req_tag;
  logic [NREQ-1:0]           gnt;
  logic [XLEN-1:0]           alu_in_a, alu_in_b;
  logic [2:0]                alu_funct3;
  logic                      alu_opt;
  fu_addr_t                  alu_addr_in;
  logic                      alu_init, alu_ack;
  logic                      alu_done;
  logic [XLEN-1:0]           alu_fu_out;
  fu_addr_t                  alu_addr_out;
  logic                      cdb_req;
  logic [XLEN-1:0]           cdb_data;
  fu_addr_t                  cdb_tag;
  logic                      cdb_gnt;
  logic [31:0]               issue_cnt;
  logic                      err;

  logic                      m_done;
  logic                      force_done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_req          (req),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_funct3   (req_funct3),
    .i_req_opt      (req_opt),
    .i_req_tag      (req_tag),
    .o_gnt          (gnt),
    .o_alu_in_a     (alu_in_a),
    .o_alu_in_b     (alu_in_b),
    .o_alu_funct3   (alu_funct3),
    .o_alu_opt      (alu_opt),
    .o_alu_addr_in  (alu_addr_in),
    .o_alu_init     (alu_init),
    .o_alu_ack      (alu_ack),
    .i_alu_done     (alu_done),
    .i_alu_fu_out   (alu_fu_out),
    .i_alu_addr_out (alu_addr_out),
    .o_cdb_req      (cdb_req),
    .o_cdb_data     (cdb_data),
    .o_cdb_tag      (cdb_tag),
    .i_cdb_gnt      (cdb_gnt),
    .o_issue_cnt    (issue_cnt),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic opt);
    case (f3)
      3'd0: alu_f = opt ? a - b : a + b;
      3'd1: alu_f = a << b[4:0];
      3'd2: alu_f = {31'b0, $signed(a) < $signed(b)};
      3'd3: alu_f = {31'b0, a < b};
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = opt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  // Latched ALU: init captures a new result (even with ack), ack alone releases it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done       <= 1'b0;
      alu_fu_out   <= '0;
      alu_addr_out <= FU_NULL;
    end else if (alu_init) begin
      m_done       <= 1'b1;
      alu_fu_out   <= alu_f(alu_in_a, alu_in_b, alu_funct3, alu_opt);
      alu_addr_out <= alu_addr_in;
    end else if (alu_ack) begin
      m_done <= 1'b0;
    end
  end

  assign alu_done = m_done | force_done;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    flush = 1'b0; req = '0; cdb_gnt = 1'b0; force_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL reset_cdb_req got %b want 0", cdb_req); end
    n_cmp++; if (alu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", alu_ack); end
    n_cmp++; if (issue_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", issue_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (alu_addr_in !== FU_NULL) begin n_bad++; $display("FAIL reset_addr_in got %h want %h", alu_addr_in, FU_NULL); end
  endtask

  task automatic test_single_op();
    do_reset();
    req = 4'b0001; req_a[0] = 32'd5; req_b[0] = 32'd7; req_funct3[0] = 3'b000;
    req_opt[0] = 1'b0; req_tag[0] = 4'd1; cdb_gnt = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %b want 0001", gnt); end
    n_cmp++; if (alu_init !== 1'b1) begin n_bad++; $display("FAIL single_init got %b want 1", alu_init); end
    n_cmp++; if (alu_in_a !== 32'd5 || alu_in_b !== 32'd7) begin n_bad++; $display("FAIL single_opnd got %0d,%0d want 5,7", alu_in_a, alu_in_b); end
    next_cycle();
    req = '0; cdb_gnt = 1'b1;
    #1;
    n_cmp++; if (cdb_req !== 1'b1) begin n_bad++; $display("FAIL single_cdb_req got %b want 1", cdb_req); end
    n_cmp++; if (cdb_data !== 32'd12) begin n_bad++; $display("FAIL single_cdb_data got %0d want 12", cdb_data); end
    n_cmp++; if (cdb_tag !== 4'd1) begin n_bad++; $display("FAIL single_cdb_tag got %0d want 1", cdb_tag); end
    n_cmp++; if (alu_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack got %b want 1", alu_ack); end
    next_cycle();
    #1;
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL single_idle got cdb_req %b want 0", cdb_req); end
    n_cmp++; if (issue_cnt !== 32'd1) begin n_bad++; $display("FAIL single_cnt got %0d want 1", issue_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    int         exp_slot [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_slot = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(100 * (i + 1)); req_b[i] = 32'(i); req_funct3[i] = 3'b000;
      req_opt[i] = 1'b0; req_tag[i] = fu_addr_t'(i + 1);
    end
    req = 4'b1111; cdb_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (gnt !== exp_gnt[k]) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_gnt[k]); end
      if (k > 0) begin
        n_cmp++;
        if (cdb_tag !== fu_addr_t'(exp_slot[k-1] + 1) || cdb_data !== 32'(101 * exp_slot[k-1] + 100)) begin
          n_bad++; $display("FAIL rr_result[%0d] got tag %0d data %0d want tag %0d data %0d", k, cdb_tag, cdb_data,
                            exp_slot[k-1] + 1, 101 * exp_slot[k-1] + 100);
        end
      end
      next_cycle();
    end
    req = '0;
    n_cmp++; if (issue_cnt !== 32'd5) begin n_bad++; $display("FAIL rr_cnt got %0d want 5", issue_cnt); end
    #1;
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd1) begin n_bad++; $display("FAIL rr_drain got req %b tag %0d want 1 1", cdb_req, cdb_tag); end
    next_cycle();
    n_cmp++; if (cdb_req !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rr_end got req %b err %b want 0 0", cdb_req, err); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    req_a[0] = 32'd3; req_b[0] = 32'd5; req_funct3[0] = 3'b000; req_opt[0] = 1'b1; req_tag[0] = 4'd2;
    req_a[1] = 32'd10; req_b[1] = 32'd4; req_funct3[1] = 3'b100; req_opt[1] = 1'b0; req_tag[1] = 4'd3;
    req = 4'b0001; cdb_gnt = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL bp_first_gnt got %b want 0001", gnt); end
    next_cycle();
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (cdb_req !== 1'b1 || cdb_data !== 32'hFFFF_FFFE || gnt !== 4'b0000 || alu_ack !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] got req %b data %h gnt %b ack %b want 1 fffffffe 0000 0",
                          k, cdb_req, cdb_data, gnt, alu_ack);
      end
      next_cycle();
    end
    cdb_gnt = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0010 || alu_init !== 1'b1 || alu_ack !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got gnt %b init %b ack %b want 0010 1 1", gnt, alu_init, alu_ack);
    end
    n_cmp++; if (cdb_data !== 32'hFFFF_FFFE || cdb_tag !== 4'd2) begin
      n_bad++; $display("FAIL bp_release_data got %h tag %0d want fffffffe 2", cdb_data, cdb_tag);
    end
    next_cycle();
    req = '0;
    #1;
    n_cmp++; if (cdb_req !== 1'b1 || cdb_data !== 32'd14 || cdb_tag !== 4'd3) begin
      n_bad++; $display("FAIL bp_next got req %b data %0d tag %0d want 1 14 3", cdb_req, cdb_data, cdb_tag);
    end
    next_cycle();
    n_cmp++; if (cdb_req !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL bp_end got req %b err %b want 0 0", cdb_req, err); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(i + 1); req_b[i] = 32'd1; req_funct3[i] = 3'b000; req_opt[i] = 1'b0; req_tag[i] = fu_addr_t'(i + 5);
    end
    req = 4'b0001; cdb_gnt = 1'b0;
    next_cycle();
    flush = 1'b1; req = 4'b0011; cdb_gnt = 1'b1;
    #1;
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL flush_cdb_req got %b want 0", cdb_req); end
    n_cmp++; if (alu_ack !== 1'b1) begin n_bad++; $display("FAIL flush_ack got %b want 1", alu_ack); end
    n_cmp++; if (gnt !== 4'b0000 || alu_init !== 1'b0) begin n_bad++; $display("FAIL flush_gnt got %b init %b want 0000 0", gnt, alu_init); end
    next_cycle();
    flush = 1'b0; cdb_gnt = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL flush_resume got %b want 0010", gnt); end
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle got cdb_req %b want 0", cdb_req); end
    next_cycle();
    req = '0; cdb_gnt = 1'b1;
    #1;
    n_cmp++; if (cdb_data !== 32'd3 || cdb_tag !== 4'd6) begin n_bad++; $display("FAIL flush_result got %0d tag %0d want 3 6", cdb_data, cdb_tag); end
    next_cycle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL flush_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'd2; req_b[i] = 32'd2; req_funct3[i] = 3'b000; req_opt[i] = 1'b0; req_tag[i] = fu_addr_t'(i + 1);
    end
    req = 4'b0010; cdb_gnt = 1'b0;
    next_cycle();
    req = 4'b1111; cdb_gnt = 1'b1; rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000 || alu_init !== 1'b0) begin n_bad++; $display("FAIL rmid_gnt got %b init %b want 0000 0", gnt, alu_init); end
    n_cmp++; if (cdb_req !== 1'b0 || alu_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_cdb got req %b ack %b want 0 0", cdb_req, alu_ack); end
    next_cycle();
    rst_n = 1'b1; cdb_gnt = 1'b0;
    #1;
    n_cmp++; if (issue_cnt !== 32'd0 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_regs got cnt %0d err %b want 0 0", issue_cnt, err); end
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL rmid_idle got cdb_req %b want 0", cdb_req); end
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr got %b want 0001", gnt); end
    next_cycle();
    req = '0; cdb_gnt = 1'b1;
    next_cycle();
  endtask

  task automatic test_error();
    do_reset();
    force_done = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pre got %b want 0", err); end
    next_cycle();
    force_done = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err); end
    repeat (3) next_cycle();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = '0; cdb_gnt = 1'b0; force_done = 1'b0;
    req_a = '0; req_b = '0; req_funct3 = '0; req_opt = '0; req_tag = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_reset_mid_op();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
